// File: rtl/mips8_pkg.sv
// mips8_pkg
// Shared definitions for the MIPS8 multicycle controller: opcode and
// controller-state enums, datapath select encodings, and a helper that
// says whether an opcode is one the controller knows how to execute.
package mips8_pkg;

    // Opcode field of the instruction register (bits 31:26).
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LB    = 6'b100000,
        OP_SB    = 6'b101000
    } opcode_t;

    // Controller states. The encoding is visible on state_dbg, so keep it
    // stable; codes 12..15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } ctrl_state_t;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the controller can sequence.
    function automatic logic is_known_op(input logic [5:0] opc);
        case (opc)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LB, OP_SB: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec
// Combinational strobe decoder for the MIPS8 controller. Turns the current
// state and fetch beat into every datapath/memory control signal.
//
// Ports:
//   reset        in   forces all strobes low while asserted
//   state        in   current controller state
//   beat         in   current fetch beat (only meaningful in S_FETCH)
//   mem_ready    in   memory handshake; qualifies fetch writes
//   op           in   opcode, only looked at in S_DECODE for illegal_op
//   mem_req .. pcsrc  out  datapath/memory strobes
//   illegal_op   out  unknown opcode seen in S_DECODE
//   state_dbg    out  state encoding, reads S_FETCH during reset
module mips_ctrl_outdec
    import mips8_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 2
) (
    input  logic              reset,
    input  ctrl_state_t       state,
    input  logic [BEAT_W-1:0] beat,
    input  logic              mem_ready,
    input  logic [5:0]        op,
    output logic              mem_req,
    output logic              iord,
    output logic              memwrite,
    output logic [BEATS-1:0]  irwrite,
    output logic              pcwrite,
    output logic              pcwrite_cond,
    output logic              regwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        aluop,
    output logic [1:0]        pcsrc,
    output logic              illegal_op,
    output logic [3:0]        state_dbg
);

    localparam logic [BEATS-1:0] LANE0 = BEATS'(1);

    // Reset overrides the state so an abandoned access stops driving
    // strobes in the very cycle reset is raised, not one cycle later.
    assign state_dbg = reset ? S_FETCH : state;

    // Everything defaults low; each state only raises what it needs.
    // During FETCH the instruction byte lane and the PC increment are
    // only written in the cycle memory actually delivers the beat.
    always_comb begin
        mem_req      = 1'b0;
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = '0;
        pcwrite      = 1'b0;
        pcwrite_cond = 1'b0;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = ALUSRCB_B;
        aluop        = ALUOP_ADD;
        pcsrc        = PCSRC_ALU;
        illegal_op   = 1'b0;

        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = ALUSRCB_ONE;
                    if (mem_ready) begin
                        irwrite = LANE0 << beat;
                        pcwrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    alusrcb    = ALUSRCB_IMM_SH;
                    illegal_op = !is_known_op(op);
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = ALUSRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = ALUSRCB_IMM;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca      = 1'b1;
                    aluop        = ALUOP_SUB;
                    pcsrc        = PCSRC_ALUOUT;
                    pcwrite_cond = 1'b1;
                end
                S_JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm
// Multicycle control unit for the MIPS8 CPU. Fetches an INSTR_W-bit
// instruction as INSTR_W/DATA_W byte-wide beats through a mem_ready
// handshake, then sequences LB/SB/RTYPE/ADDI/BEQ/J.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   op                opcode from the instruction register
//   zero              ALU zero flag (the PC gating is done by the datapath
//                     with pcwrite_cond)
//   mem_ready         memory accepted/returned the current beat
//   mem_req, iord, memwrite        memory interface strobes
//   irwrite           one-hot instruction-register lane write enable
//   pcwrite, pcwrite_cond, regwrite, regdst, memtoreg,
//   alusrca, alusrcb, aluop, pcsrc datapath strobes
//   illegal_op        one-cycle pulse for an unknown opcode
//   state_dbg         current state encoding
module mips_ctrl_fsm
    import mips8_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [5:0]                  op,
    input  logic                        zero,
    input  logic                        mem_ready,
    output logic                        mem_req,
    output logic                        iord,
    output logic                        memwrite,
    output logic [INSTR_W/DATA_W-1:0]   irwrite,
    output logic                        pcwrite,
    output logic                        pcwrite_cond,
    output logic                        regwrite,
    output logic                        regdst,
    output logic                        memtoreg,
    output logic                        alusrca,
    output logic [1:0]                  alusrcb,
    output logic [1:0]                  aluop,
    output logic [1:0]                  pcsrc,
    output logic                        illegal_op,
    output logic [3:0]                  state_dbg
);

    localparam int BEATS  = INSTR_W / DATA_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    ctrl_state_t       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    // The branch decision itself lives in the datapath (pcwrite_cond AND
    // zero), so the controller never looks at the flag.
    logic unused_zero;
    assign unused_zero = zero;

    // State register and fetch beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic. The beat counter only moves in FETCH on an
    // accepted beat and returns to zero when the last beat hands over to
    // DECODE. Unused encodings fall back to a clean FETCH at beat 0.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DECODE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LB) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SB) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default: begin
                state_d = S_FETCH;
                beat_d  = '0;
            end
        endcase
    end

    mips_ctrl_outdec #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_outdec (
        .reset        (reset),
        .state        (state_q),
        .beat         (beat_q),
        .mem_ready    (mem_ready),
        .op           (op),
        .mem_req      (mem_req),
        .iord         (iord),
        .memwrite     (memwrite),
        .irwrite      (irwrite),
        .pcwrite      (pcwrite),
        .pcwrite_cond (pcwrite_cond),
        .regwrite     (regwrite),
        .regdst       (regdst),
        .memtoreg     (memtoreg),
        .alusrca      (alusrca),
        .alusrcb      (alusrcb),
        .aluop        (aluop),
        .pcsrc        (pcsrc),
        .illegal_op   (illegal_op),
        .state_dbg    (state_dbg)
    );

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb_mips_ctrl_fsm
// Bench for the MIPS8 controller. Two instances share all inputs: one with
// 8-bit data (4 fetch beats) and one with 16-bit data (2 fetch beats); a
// select chooses which one is being scored. Every cycle the expected
// strobe vector is pushed to a queue as the inputs are driven and popped at
// the following falling edge to compare with the selected instance.
module tb_mips_ctrl_fsm;
    import mips8_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic [3:0] irwrite;
        logic       pcwrite;
        logic       pcwrite_cond;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal_op;
        logic [3:0] state_dbg;
    } outs_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       sel16;

    logic       d8_mem_req, d8_iord, d8_memwrite, d8_pcwrite, d8_pcwrite_cond;
    logic       d8_regwrite, d8_regdst, d8_memtoreg, d8_alusrca, d8_illegal_op;
    logic [3:0] d8_irwrite, d8_state_dbg;
    logic [1:0] d8_alusrcb, d8_aluop, d8_pcsrc;

    logic       d16_mem_req, d16_iord, d16_memwrite, d16_pcwrite, d16_pcwrite_cond;
    logic       d16_regwrite, d16_regdst, d16_memtoreg, d16_alusrca, d16_illegal_op;
    logic [1:0] d16_irwrite;
    logic [3:0] d16_state_dbg;
    logic [1:0] d16_alusrcb, d16_aluop, d16_pcsrc;

    outs_t act_vec;
    outs_t exp_q[$];

    ctrl_state_t m_state;
    int          m_beat;
    int          m_beats;

    int    total_checks;
    int    bad_checks;
    int    cyc_no;
    string cur_test;

    mips_ctrl_fsm #(.DATA_W(8), .INSTR_W(32)) dut8 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(d8_mem_req), .iord(d8_iord), .memwrite(d8_memwrite),
        .irwrite(d8_irwrite), .pcwrite(d8_pcwrite), .pcwrite_cond(d8_pcwrite_cond),
        .regwrite(d8_regwrite), .regdst(d8_regdst), .memtoreg(d8_memtoreg),
        .alusrca(d8_alusrca), .alusrcb(d8_alusrcb), .aluop(d8_aluop),
        .pcsrc(d8_pcsrc), .illegal_op(d8_illegal_op), .state_dbg(d8_state_dbg)
    );

    mips_ctrl_fsm #(.DATA_W(16), .INSTR_W(32)) dut16 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(d16_mem_req), .iord(d16_iord), .memwrite(d16_memwrite),
        .irwrite(d16_irwrite), .pcwrite(d16_pcwrite), .pcwrite_cond(d16_pcwrite_cond),
        .regwrite(d16_regwrite), .regdst(d16_regdst), .memtoreg(d16_memtoreg),
        .alusrca(d16_alusrca), .alusrcb(d16_alusrcb), .aluop(d16_aluop),
        .pcsrc(d16_pcsrc), .illegal_op(d16_illegal_op), .state_dbg(d16_state_dbg)
    );

    assign act_vec = sel16 ?
        {d16_mem_req, d16_iord, d16_memwrite, {2'b00, d16_irwrite}, d16_pcwrite,
         d16_pcwrite_cond, d16_regwrite, d16_regdst, d16_memtoreg, d16_alusrca,
         d16_alusrcb, d16_aluop, d16_pcsrc, d16_illegal_op, d16_state_dbg} :
        {d8_mem_req, d8_iord, d8_memwrite, d8_irwrite, d8_pcwrite,
         d8_pcwrite_cond, d8_regwrite, d8_regdst, d8_memtoreg, d8_alusrca,
         d8_alusrcb, d8_aluop, d8_pcsrc, d8_illegal_op, d8_state_dbg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected strobes for one cycle, written straight from the control table.
    function automatic outs_t model_outs(input logic rst, input ctrl_state_t st, input int bt,
                                         input logic [5:0] opc, input logic mr);
        outs_t o;
        o = '0;
        if (rst) begin
            o.state_dbg = 4'd0;
            return o;
        end
        o.state_dbg = st;
        case (st)
            S_FETCH: begin
                o.mem_req = 1'b1;
                o.alusrcb = 2'b01;
                if (mr) begin
                    o.irwrite = 4'(1 << bt);
                    o.pcwrite = 1'b1;
                end
            end
            S_DECODE: begin
                o.alusrcb    = 2'b11;
                o.illegal_op = !(opc inside {6'b100000, 6'b101000, 6'b000000,
                                             6'b001000, 6'b000100, 6'b000010});
            end
            S_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            S_MEMRD:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
            S_MEMWB:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            S_MEMWR:  begin o.mem_req = 1'b1; o.iord = 1'b1; o.memwrite = 1'b1; end
            S_EXEC:   begin o.alusrca = 1'b1; o.aluop = 2'b10; end
            S_ALUWB:  begin o.regwrite = 1'b1; o.regdst = 1'b1; end
            S_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            S_ADDIWB: begin o.regwrite = 1'b1; end
            S_BRANCH: begin
                o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwrite_cond = 1'b1;
            end
            S_JUMP:   begin o.pcwrite = 1'b1; o.pcsrc = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    // Advance the reference state using the inputs that were just clocked in.
    task automatic model_step();
        if (reset) begin
            m_state = S_FETCH;
            m_beat  = 0;
        end else begin
            case (m_state)
                S_FETCH:
                    if (mem_ready) begin
                        if (m_beat == m_beats - 1) begin
                            m_state = S_DECODE;
                            m_beat  = 0;
                        end else begin
                            m_beat++;
                        end
                    end
                S_DECODE:
                    case (op)
                        6'b100000, 6'b101000: m_state = S_MEMADR;
                        6'b000000:            m_state = S_EXEC;
                        6'b001000:            m_state = S_ADDIEX;
                        6'b000100:            m_state = S_BRANCH;
                        6'b000010:            m_state = S_JUMP;
                        default:              m_state = S_FETCH;
                    endcase
                S_MEMADR: m_state = (op == 6'b100000) ? S_MEMRD :
                                    (op == 6'b101000) ? S_MEMWR : S_FETCH;
                S_MEMRD:  if (mem_ready) m_state = S_MEMWB;
                S_MEMWR:  if (mem_ready) m_state = S_FETCH;
                S_EXEC:   m_state = S_ALUWB;
                S_ADDIEX: m_state = S_ADDIWB;
                default:  m_state = S_FETCH;
            endcase
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_step();
        cyc_no++;
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] opc, input logic zr, input logic mr);
        reset     = rst;
        op        = opc;
        zero      = zr;
        mem_ready = mr;
        exp_q.push_back(model_outs(rst, m_state, m_beat, opc, mr));
    endtask

    // Scoreboard consumer: one expected vector per cycle, compared mid-cycle.
    initial begin
        outs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("%s@%0d", cur_test, cyc_no), 32'(act_vec), 32'(e));
            end
        end
    end

    // Runs one instruction from FETCH beat 0 back to FETCH, optionally
    // stalling one fetch beat and the data access, and checks its length
    // in cycles as seen on the DUT state_dbg. op is randomised outside
    // DECODE/MEMADR because it must not matter there.
    task automatic runInstr(input string name, input logic [5:0] opc, input logic zr,
                            input int fw_beat, input int fw_n, input int mw_n,
                            input int exp_cycles);
        int         n;
        int         fw;
        int         mw;
        bit         left;
        bit         done;
        logic       mr;
        logic [5:0] drv_op;
        logic [3:0] obs;
        cur_test = name;
        n = 0; fw = fw_n; mw = mw_n; left = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            mr = 1'b1;
            if (m_state == S_FETCH && m_beat == fw_beat && fw > 0) begin
                mr = 1'b0;
                fw--;
            end
            if ((m_state == S_MEMRD || m_state == S_MEMWR) && mw > 0) begin
                mr = 1'b0;
                mw--;
            end
            drv_op = (m_state == S_DECODE || m_state == S_MEMADR) ? opc : 6'($urandom);
            applyStimulus(1'b0, drv_op, zr, mr);
            n++;
            advance();
            obs = sel16 ? d16_state_dbg : d8_state_dbg;
            if (obs != 4'd0) left = 1'b1;
            else if (left) done = 1'b1;
        end
        checkOutput({name, " cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    // Start a store, stall it in MEMWR, then pull reset in the middle of
    // the stalled access and restart with an RTYPE instruction.
    task automatic resetDuringStore(input string name, input int exp_rtype);
        cur_test = name;
        for (int i = 0; i < 20 && m_state != S_MEMWR; i++) begin
            applyStimulus(1'b0, 6'b101000, 1'b0, 1'b1);
            advance();
        end
        checkOutput({name, " reached_memwr"}, 32'(sel16 ? d16_state_dbg : d8_state_dbg), 32'(S_MEMWR));
        repeat (2) begin
            applyStimulus(1'b0, 6'b101000, 1'b0, 1'b0);
            advance();
        end
        applyStimulus(1'b1, 6'b101000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput({name, " rst_strobes"},
                    32'({(sel16 ? d16_mem_req : d8_mem_req), (sel16 ? d16_memwrite : d8_memwrite)}),
                    32'(0));
        advance();
        runInstr({name, "_rtype"}, 6'b000000, 1'b0, 0, 0, 0, exp_rtype);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        cyc_no       = 0;
        sel16        = 1'b0;
        m_beats      = 4;
        m_state      = S_FETCH;
        m_beat       = 0;
        reset        = 1'b1;
        op           = 6'b000000;
        zero         = 1'b0;
        mem_ready    = 1'b0;
        cur_test     = "reset";

        $display("[TB] starting 4-beat controller");
        repeat (3) begin
            advance();
            applyStimulus(1'b1, 6'b000000, 1'b0, 1'b1);
        end
        advance();

        runInstr("rtype",    6'b000000, 1'b0, 0, 0, 0, 7);
        runInstr("lb_waits", 6'b100000, 1'b0, 1, 2, 3, 13);
        runInstr("sb",       6'b101000, 1'b0, 0, 0, 0, 7);
        runInstr("sb_waits", 6'b101000, 1'b0, 3, 1, 2, 10);
        runInstr("addi",     6'b001000, 1'b0, 0, 0, 0, 7);
        runInstr("beq_z",    6'b000100, 1'b1, 0, 0, 0, 6);
        runInstr("beq_nz",   6'b000100, 1'b0, 0, 0, 0, 6);
        runInstr("j",        6'b000010, 1'b0, 0, 0, 0, 6);
        runInstr("illegal",  6'b111111, 1'b0, 0, 0, 0, 5);
        runInstr("lb",       6'b100000, 1'b0, 0, 0, 0, 8);
        resetDuringStore("rst_memwr", 7);

        $display("[TB] switching to 2-beat controller");
        sel16    = 1'b1;
        m_beats  = 2;
        cur_test = "reset16";
        repeat (2) begin
            applyStimulus(1'b1, 6'b000000, 1'b0, 1'b1);
            advance();
        end

        runInstr("rtype16",    6'b000000, 1'b0, 0, 0, 0, 5);
        runInstr("lb16_waits", 6'b100000, 1'b0, 1, 1, 2, 9);
        runInstr("beq16",      6'b000100, 1'b1, 0, 0, 0, 4);
        runInstr("illegal16",  6'b010101, 1'b0, 0, 0, 0, 3);
        resetDuringStore("rst_memwr16", 5);
        runInstr("j16",        6'b000010, 1'b0, 0, 0, 0, 4);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
